// File: rtl/dma_sink_pkg.sv
// Shared types and helpers for the DMA row sink.
package dma_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } st_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_sink_fifo.sv
// Synchronous show-ahead FIFO with separate occupancy counter.
module dma_sink_fifo
    import dma_sink_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [7:0]                din,
    input  logic                      pop,
    output logic [7:0]                dout,
    output logic                      empty,
    output logic                      full,
    output logic [lvl_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + AW'(1);
            end
            if (pop_ok) begin
                rp <= rp + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dma_row_sink.sv
// Requests bytes from the DMA controller one DRQ/DACK handshake at a time
// and buffers them for the row consumer.
module dma_row_sink
    import dma_sink_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LENW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LENW-1:0]          len,
    input  logic                     dack,
    input  logic                     iowe_n,
    input  logic [7:0]               idata,
    output logic                     drq,
    input  logic                     rd,
    output logic [7:0]               odata,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic                     udf
);

    st_t            st;
    st_t            st_n;
    logic [LENW-1:0] remain;
    logic [LENW-1:0] remain_n;
    logic           exwe_n;
    logic           wr;
    logic           full;
    logic           drq_n;
    logic           done_n;

    assign wr   = dack & ~iowe_n & exwe_n;
    assign busy = (st != IDLE);

    dma_sink_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(start),
        .push (wr & ~start),
        .din  (idata),
        .pop  (rd),
        .dout (odata),
        .empty(empty),
        .full (full),
        .level(level)
    );

    always_comb begin
        st_n     = st;
        remain_n = remain;
        done_n   = 1'b0;
        if (start) begin
            remain_n = len;
            st_n     = (len != '0) ? REQ : IDLE;
        end else begin
            unique case (st)
                IDLE: ;
                REQ: begin
                    if (wr) begin
                        remain_n = remain - LENW'(1);
                        done_n   = (remain == LENW'(1));
                        st_n     = done_n ? IDLE : ACK;
                    end
                end
                ACK: begin
                    if (!dack) begin
                        st_n = REQ;
                    end
                end
                default: st_n = IDLE;
            endcase
        end
        // a flush in the same cycle frees the whole FIFO
        drq_n = (st_n == REQ) && (start || !full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            remain <= '0;
            exwe_n <= 1'b1;
            drq    <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            st     <= st_n;
            remain <= remain_n;
            exwe_n <= iowe_n;
            drq    <= drq_n;
            done   <= done_n;
            if (start) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (wr && full) begin
                    ovf <= 1'b1;
                end
                if (rd && empty) begin
                    udf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_row_sink.sv
// Scoreboard bench for dma_row_sink with a simple K580VT57 controller model.
module tb_dma_row_sink;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic       dack;
    logic       iowe_n;
    logic [7:0] idata;
    logic       drq;
    logic       rd;
    logic [7:0] odata;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       udf;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0] sb [$];

    dma_row_sink #(
        .DEPTH(16),
        .LENW (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .dack  (dack),
        .iowe_n(iowe_n),
        .idata (idata),
        .drq   (drq),
        .rd    (rd),
        .odata (odata),
        .empty (empty),
        .level (level),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!drq && n < 300) begin
            tick();
            n++;
        end
        if (!drq) begin
            chk("drq_timeout", 32'(drq), 32'd1);
            return;
        end
        sb.push_back(b);
        dack   = 1'b1;
        idata  = b;
        iowe_n = 1'b0;
        tick();
        chk("drq_fall", 32'(drq), 32'd0);
        iowe_n = 1'b1;
        tick();
        dack = 1'b0;
        tick();
    endtask

    task automatic pop_chk();
        if (sb.size() == 0) begin
            chk("sb_underrun", 32'(empty), 32'd1);
            return;
        end
        chk("odata", 32'(odata), 32'(sb.pop_front()));
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        int d0;
        int popped;
        int lmax;
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        len    = '0;
        dack   = 1'b0;
        iowe_n = 1'b1;
        idata  = '0;
        rd     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_drq",   32'(drq),   0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_done",  32'(done),  0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf",   32'(ovf),   0);
        chk("rst_udf",   32'(udf),   0);

        // 1: basic transfer
        d0 = done_cnt;
        do_start(8'd3);
        chk("t1_drq_rise", 32'(drq), 1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        chk("t1_done", 32'(done_cnt - d0), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_level", 32'(level), 3);
        repeat (3) pop_chk();
        chk("t1_empty", 32'(empty), 1);

        // 2: backpressure
        d0 = done_cnt;
        do_start(8'd20);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        repeat (3) tick();
        chk("t2_drq_low", 32'(drq), 0);
        chk("t2_level", 32'(level), 16);
        chk("t2_busy", 32'(busy), 1);
        repeat (4) pop_chk();
        for (int i = 16; i < 20; i++) send_byte(8'(8'h40 + i));
        chk("t2_done", 32'(done_cnt - d0), 1);
        chk("t2_ovf", 32'(ovf), 0);
        while (sb.size() > 0) pop_chk();
        chk("t2_empty", 32'(empty), 1);

        // 3: concurrent traffic with wrap-around
        d0 = done_cnt;
        popped = 0;
        lmax = 0;
        do_start(8'd40);
        fork
            begin
                for (int i = 0; i < 40; i++) send_byte(8'($urandom));
            end
            begin
                n = 0;
                while (popped < 40 && n < 3000) begin
                    if (int'(level) > lmax) lmax = int'(level);
                    if (!empty && sb.size() > 0) begin
                        pop_chk();
                        popped++;
                    end
                    tick();
                    n++;
                end
            end
        join
        chk("t3_popped", popped, 40);
        chk("t3_lmax_ok", 32'(lmax <= 16), 1);
        chk("t3_done", 32'(done_cnt - d0), 1);
        chk("t3_empty", 32'(empty), 1);

        // 4: restart mid-transfer
        d0 = done_cnt;
        do_start(8'd5);
        send_byte(8'hA1);
        send_byte(8'hA2);
        do_start(8'd2);
        sb.delete();
        chk("t4_flush", 32'(level), 0);
        chk("t4_busy", 32'(busy), 1);
        send_byte(8'hB1);
        chk("t4_no_done", 32'(done_cnt - d0), 0);
        send_byte(8'hB2);
        chk("t4_done", 32'(done_cnt - d0), 1);
        repeat (3) tick();
        chk("t4_drq_idle", 32'(drq), 0);
        chk("t4_level", 32'(level), 2);
        repeat (2) pop_chk();

        // 5: error flags
        do_start(8'd16);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i));
        dack   = 1'b1;
        idata  = 8'hEE;
        iowe_n = 1'b0;
        tick();
        iowe_n = 1'b1;
        dack   = 1'b0;
        tick();
        chk("t5_ovf", 32'(ovf), 1);
        chk("t5_level", 32'(level), 16);
        while (sb.size() > 0) pop_chk();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        repeat (2) tick();
        chk("t5_udf", 32'(udf), 1);
        chk("t5_ovf_sticky", 32'(ovf), 1);
        chk("t5_empty", 32'(empty), 1);
        do_start(8'd0);
        chk("t5_ovf_clr", 32'(ovf), 0);
        chk("t5_udf_clr", 32'(udf), 0);

        // 6: reset in ACK, then zero length
        do_start(8'd3);
        dack   = 1'b1;
        idata  = 8'h77;
        iowe_n = 1'b0;
        tick();
        iowe_n = 1'b1;
        chk("t6_in_ack", 32'(busy && !drq), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dack  = 1'b0;
        chk("t6_drq", 32'(drq), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_level", 32'(level), 0);
        d0 = done_cnt;
        do_start(8'd0);
        chk("t6_z_drq", 32'(drq), 0);
        repeat (4) tick();
        chk("t6_z_drq2", 32'(drq), 0);
        chk("t6_z_busy", 32'(busy), 0);
        chk("t6_z_done", 32'(done_cnt - d0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_row_sink.md
# dma_row_sink

DMA-side peripheral that requests a programmed number of bytes from the K580VT57 DMA controller one byte per DRQ/DACK handshake. It captures each byte on the controller's I/O-write strobe and buffers it in a small show-ahead FIFO. A consumer, typically the CRT row fetch, drains the FIFO at its own pace. The block sits between the DMA channel's drq/dack/oiowe_n pins plus the system data bus and the video/consumer logic.

## Interface

**Parameters**
- `DEPTH`, default 16: FIFO entries; must be a power of two and at least 2.
- `LENW`, default 8: width of the byte-count register.

**Ports**
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse. Loads `len`, flushes the FIFO, begins requesting.
- `len` in LENW: number of bytes to fetch. A value of 0 means nothing is fetched.
- `dack` in 1: DMA acknowledge for this channel.
- `iowe_n` in 1: DMA I/O-write strobe, active low.
- `idata` in 8: system data bus.
- `drq` out 1: DMA request, registered.
- `rd` in 1: consumer pop. Ignored when `empty`.
- `odata` out 8: FIFO head (show-ahead). Valid only while `!empty`.
- `empty` out 1: FIFO empty.
- `level` out $clog2(DEPTH)+1: number of occupied entries.
- `busy` out 1: a transfer is in progress (state is not IDLE).
- `done` out 1: one-cycle pulse on acceptance of the last byte.
- `ovf` out 1: sticky flag. Set when a write strobe arrives while the FIFO is full. Cleared by `reset` or `start`.
- `udf` out 1: sticky flag. Set on `rd` while empty. Cleared by `reset` or `start`.

## Operation

**Registers**
- `remain` (LENW bits): bytes still to request.
- `exwe_n`: `iowe_n` delayed by one clock.
- FSM `st`.

**Write detect.** A write is detected when `dack & ~iowe_n & exwe_n`, i.e. on a falling edge of `iowe_n` while `dack` is high.
- If the FIFO is not full: push `idata`.
- If the FIFO is full: drop the byte and set `ovf`.

**FSM**
- **IDLE** (`drq`=0)
  - `start` with `len`≠0: `remain` ← `len`, go to REQ.
  - `start` with `len`=0: stay in IDLE, no `done` pulse.
- **REQ** (`drq`=1 only when `level` < DEPTH; otherwise `drq` is held low and the state waits)
  - On write detect: `remain` ← `remain` − 1, go to ACK.
  - If `remain` was 1: pulse `done` and go to IDLE instead.
- **ACK** (`drq`=0)
  - Wait for `dack`=0, then return to REQ.
  - This is required because the controller holds T2 until DRQ falls and only then drops DACK.
- **`start` in any state:** restarts the transfer.
  - Flushes the FIFO.
  - Clears `ovf`/`udf`.
  - Reloads `remain`.
  - Enters REQ (or IDLE if `len`=0).
  - A write detected in the same cycle is discarded.

**FIFO**
- Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `level` is a separate counter.
- Simultaneous push and pop (not empty, not full) leaves `level` unchanged.
- Simultaneous push and pop when full is impossible under normal operation because `drq` is gated. A stray push when full is dropped even if a pop occurs in the same cycle.
- Pop when empty has no effect other than setting `udf`.

**Reset values**
- `drq`=0, `busy`=0, `done`=0, `empty`=1, `level`=0, `ovf`=0, `udf`=0.
- `odata` is don't-care.
- State is IDLE and `exwe_n`=1.
- Reset mid-transfer abandons the transfer. `drq` is low in the cycle after reset.

## Timing

- `drq` is registered. It rises on the clock after `start`, and on the clock after `dack` is seen low in ACK.
- `drq` falls on the clock after write detect. The controller's T2 therefore ends within one ce tick.
- Push latency: the byte is visible at `odata`, with `empty`=0, on the clock after write detect.
- Pop: `odata` advances and `level` decrements on the clock after `rd`.
- `done` is asserted in the same cycle that `busy` falls.
- Only one byte is accepted per DACK cycle. Further `iowe_n` edges while in ACK are still pushed if space allows; the controller never generates them.

## Structure

- Package `dma_sink_pkg` contains:
  - FSM state enumeration: IDLE=2'd0, REQ=2'd1, ACK=2'd2.
  - A `clog2`-derived level width helper.
- Sub-module `dma_sink_fifo` is a synchronous show-ahead FIFO.
  - Interface: `clk`, `reset`, `flush`, `push`, `din`, `pop`, `dout`, `empty`, `full`, `level`.
- The top level holds the FSM, edge detect, counter and flags.

## Test plan

1. **Basic transfer.** `start`, `len`=3. Controller model sends 0x11, 0x22, 0x33 with a full DRQ/DACK handshake each.
   - `drq` drops after each byte.
   - `done` pulses once, after 0x33.
   - `level`=3; popping yields 0x11, 0x22, 0x33, then `empty`=1.
2. **Backpressure.** DEPTH=16, `len`=20, no pops.
   - `drq` stays low after 16 bytes, with `level`=16 and `busy`=1.
   - Pop 4 bytes: `drq` re-rises and the remaining 4 bytes are accepted.
   - `done` pulses; no `ovf`.
3. **Concurrent traffic and wrap-around.** `len`=40 with a pop every other clock and writes interleaved.
   - All 40 bytes are popped in order across pointer wrap.
   - `level` stays ≤16.
4. **Restart mid-transfer.** `start` with `len`=5, receive 2 bytes, then `start` with `len`=2.
   - FIFO is flushed (`level`=0) and `remain`=2.
   - Exactly 2 further bytes are accepted before `done`.
5. **Error flags.** Force a write strobe while full (model ignores `drq`), then `rd` while empty.
   - `ovf`=1 and `udf`=1, both sticky.
   - The FIFO contents are unchanged by the dropped byte.
   - Both flags are cleared by the next `start`.
6. **Reset and zero length.** Assert `reset` while in ACK.
   - Next cycle: `drq`=0, `busy`=0, `empty`=1, `level`=0.
   - `start` with `len`=0 afterwards: `drq` stays 0 and no `done` pulse.
